// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU core: pipeline state encoding, writeback
// source select values, special register indices and NZP flag bit positions.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    localparam logic [1:0] REG_SRC_ALU = 2'b00;
    localparam logic [1:0] REG_SRC_LSU = 2'b01;
    localparam logic [1:0] REG_SRC_IMM = 2'b10;

    localparam logic [3:0] R_BLOCK_ID  = 4'd13;
    localparam logic [3:0] R_BLOCK_DIM = 4'd14;
    localparam logic [3:0] R_THREAD_ID = 4'd15;

    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

endpackage

// File: rtl/thread_regfile_if.sv
// Decoded-instruction, datapath and result signals exchanged between a core
// and one thread_regfile lane.
interface thread_regfile_if
    import gpu_pkg::*;
#(
    parameter int DATA_BITS = 8
);
    logic                 enable;
    logic [DATA_BITS-1:0] block_id;
    core_state_t          core_state;
    logic [3:0]           decoded_rd_address;
    logic [3:0]           decoded_rs_address;
    logic [3:0]           decoded_rt_address;
    logic                 decoded_reg_write_enable;
    logic [1:0]           decoded_reg_input_mux;
    logic [DATA_BITS-1:0] decoded_immediate;
    logic                 decoded_nzp_write_enable;
    logic [2:0]           decoded_nzp;
    logic [DATA_BITS-1:0] alu_out;
    logic [DATA_BITS-1:0] lsu_out;
    logic [DATA_BITS-1:0] rs;
    logic [DATA_BITS-1:0] rt;
    logic [2:0]           nzp;
    logic                 branch_taken;

    modport master (
        output enable, block_id, core_state,
        output decoded_rd_address, decoded_rs_address, decoded_rt_address,
        output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        output decoded_nzp_write_enable, decoded_nzp, alu_out, lsu_out,
        input  rs, rt, nzp, branch_taken
    );

    modport slave (
        input  enable, block_id, core_state,
        input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
        input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
        input  decoded_nzp_write_enable, decoded_nzp, alu_out, lsu_out,
        output rs, rt, nzp, branch_taken
    );

endinterface

// File: rtl/thread_regfile_nzp_unit.sv
// NZP flag register: captures compare flags in UPDATE and registers the
// branch decision in EXECUTE from the flags stored before that edge.
module nzp_unit
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  core_state_t core_state,
    input  logic        nzp_write_enable,
    input  logic [2:0]  decoded_nzp,
    input  logic [2:0]  alu_flags,
    output logic [2:0]  nzp,
    output logic        branch_taken
);

    // NOTE: state registers use non-blocking assignment so branch_taken sees
    // the pre-edge nzp even though both registers share this block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzp          <= 3'b000;
            branch_taken <= 1'b0;
        end else if (enable) begin
            if (core_state == CORE_EXECUTE)
                branch_taken <= |(nzp & decoded_nzp);
            if (core_state == CORE_UPDATE && nzp_write_enable)
                nzp <= alu_flags;
        end
    end

endmodule

// File: rtl/thread_regfile.sv
// Per-thread register file: R0-R12 writable, R13-R15 read-only specials.
// Operands are registered in REQUEST, writeback happens in UPDATE.
module thread_regfile
    import gpu_pkg::*;
#(
    parameter int THREAD_ID         = 0,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int DATA_BITS         = 8
) (
    input logic             clk,
    input logic             reset_n,
    thread_regfile_if.slave bus
);

    localparam int                   NUM_GPRS  = 13;
    localparam logic [DATA_BITS-1:0] BLOCK_DIM = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] LANE_ID   = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] regs [NUM_GPRS];
    logic [DATA_BITS-1:0] rs_q;
    logic [DATA_BITS-1:0] rt_q;
    logic [DATA_BITS-1:0] wb_data;
    logic                 wb_valid;

    function automatic logic [DATA_BITS-1:0] read_reg(input logic [3:0] addr);
        if (addr == R_BLOCK_ID)  return bus.block_id;
        if (addr == R_BLOCK_DIM) return BLOCK_DIM;
        if (addr == R_THREAD_ID) return LANE_ID;
        return regs[addr];
    endfunction

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        wb_valid = 1'b0;
        wb_data  = '0;
        case (bus.decoded_reg_input_mux)
            REG_SRC_ALU: begin wb_valid = 1'b1; wb_data = bus.alu_out;           end
            REG_SRC_LSU: begin wb_valid = 1'b1; wb_data = bus.lsu_out;           end
            REG_SRC_IMM: begin wb_valid = 1'b1; wb_data = bus.decoded_immediate; end
            default:     ;
        endcase
    end

    // NOTE: the register array is reset because software relies on R0-R12
    // starting at zero; it is small enough to stay in flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GPRS; i++) regs[i] <= '0;
            rs_q <= '0;
            rt_q <= '0;
        end else if (bus.enable) begin
            if (bus.core_state == CORE_REQUEST) begin
                rs_q <= read_reg(bus.decoded_rs_address);
                rt_q <= read_reg(bus.decoded_rt_address);
            end
            if (bus.core_state == CORE_UPDATE && bus.decoded_reg_write_enable &&
                wb_valid && bus.decoded_rd_address < R_BLOCK_ID)
                regs[bus.decoded_rd_address] <= wb_data;
        end
    end

    assign bus.rs = rs_q;
    assign bus.rt = rt_q;

    nzp_unit u_nzp (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (bus.enable),
        .core_state       (bus.core_state),
        .nzp_write_enable (bus.decoded_nzp_write_enable),
        .decoded_nzp      (bus.decoded_nzp),
        .alu_flags        ({bus.alu_out[NZP_N], bus.alu_out[NZP_Z], bus.alu_out[NZP_P]}),
        .nzp              (bus.nzp),
        .branch_taken     (bus.branch_taken)
    );

endmodule

// File: tb/tb_thread_regfile.sv
// Self-checking bench for thread_regfile: directed scenarios with literal
// expectations, then random traffic compared every cycle against a model.
module tb_thread_regfile;
    import gpu_pkg::*;

    localparam int TID = 2;
    localparam int TPB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   compare_on = 1'b0;

    always #5 clk = ~clk;

    thread_regfile_if #(.DATA_BITS(8)) bus ();

    thread_regfile #(
        .THREAD_ID         (TID),
        .THREADS_PER_BLOCK (TPB),
        .DATA_BITS         (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Reference: architectural state as plain variables
    logic [7:0] m_reg [16];
    logic [7:0] m_rs, m_rt;
    logic [2:0] m_nzp;
    logic       m_bt;

    function automatic logic [7:0] arch_read(input int a);
        case (a)
            13:      return bus.block_id;
            14:      return 8'(TPB);
            15:      return 8'(TID);
            default: return m_reg[a];
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
            m_rs = 8'h00; m_rt = 8'h00; m_nzp = 3'b000; m_bt = 1'b0;
        end else if (bus.enable) begin
            case (bus.core_state)
                CORE_REQUEST: begin
                    m_rs = arch_read(int'(bus.decoded_rs_address));
                    m_rt = arch_read(int'(bus.decoded_rt_address));
                end
                CORE_EXECUTE: m_bt = (m_nzp & bus.decoded_nzp) != 3'b000;
                CORE_UPDATE: begin
                    if (bus.decoded_reg_write_enable && bus.decoded_rd_address < 4'd13) begin
                        if (bus.decoded_reg_input_mux == 2'b00) m_reg[bus.decoded_rd_address] = bus.alu_out;
                        if (bus.decoded_reg_input_mux == 2'b01) m_reg[bus.decoded_rd_address] = bus.lsu_out;
                        if (bus.decoded_reg_input_mux == 2'b10) m_reg[bus.decoded_rd_address] = bus.decoded_immediate;
                    end
                    if (bus.decoded_nzp_write_enable) m_nzp = bus.alu_out[2:0];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_on && reset_n) begin
            check("cmp_rs",  32'(bus.rs),           32'(m_rs));
            check("cmp_rt",  32'(bus.rt),           32'(m_rt));
            check("cmp_nzp", 32'(bus.nzp),          32'(m_nzp));
            check("cmp_bt",  32'(bus.branch_taken), 32'(m_bt));
        end
    end

    task automatic cyc(input core_state_t s);
        bus.core_state = s;
        @(negedge clk);
        bus.core_state = CORE_IDLE;
    endtask

    task automatic clear_decode();
        bus.decoded_reg_write_enable = 1'b0;
        bus.decoded_nzp_write_enable = 1'b0;
        bus.decoded_reg_input_mux    = REG_SRC_ALU;
    endtask

    initial begin
        bus.enable = 1'b1; bus.block_id = 8'h00; bus.core_state = CORE_IDLE;
        bus.decoded_rd_address = 4'd0; bus.decoded_rs_address = 4'd0; bus.decoded_rt_address = 4'd0;
        bus.decoded_reg_write_enable = 1'b0; bus.decoded_reg_input_mux = 2'b00;
        bus.decoded_immediate = 8'h00; bus.decoded_nzp_write_enable = 1'b0;
        bus.decoded_nzp = 3'b000; bus.alu_out = 8'h00; bus.lsu_out = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_rs",  32'(bus.rs), 32'h0);
        check("rst_nzp", 32'(bus.nzp), 32'h0);
        check("rst_bt",  32'(bus.branch_taken), 32'h0);
        reset_n = 1'b1;
        compare_on = 1'b1;

        bus.decoded_rs_address = 4'd5;
        cyc(CORE_REQUEST);
        check("r5_after_reset", 32'(bus.rs), 32'h0);

        // Writeback from ALU and immediate
        bus.decoded_reg_write_enable = 1'b1;
        bus.decoded_rd_address = 4'd3; bus.decoded_reg_input_mux = REG_SRC_ALU; bus.alu_out = 8'h2A;
        cyc(CORE_UPDATE);
        bus.decoded_rd_address = 4'd4; bus.decoded_reg_input_mux = REG_SRC_IMM; bus.decoded_immediate = 8'h7F;
        cyc(CORE_UPDATE);
        clear_decode();
        bus.decoded_rs_address = 4'd3; bus.decoded_rt_address = 4'd4;
        cyc(CORE_REQUEST);
        check("wb_alu_r3", 32'(bus.rs), 32'h2A);
        check("wb_imm_r4", 32'(bus.rt), 32'h7F);

        // Special registers, write to R14 ignored
        bus.block_id = 8'h05;
        bus.decoded_rs_address = 4'd13; bus.decoded_rt_address = 4'd15;
        cyc(CORE_REQUEST);
        check("r13_block_id", 32'(bus.rs), 32'h05);
        check("r15_thread_id", 32'(bus.rt), 32'h02);
        bus.decoded_reg_write_enable = 1'b1; bus.decoded_rd_address = 4'd14;
        bus.decoded_reg_input_mux = REG_SRC_IMM; bus.decoded_immediate = 8'hFF;
        cyc(CORE_UPDATE);
        clear_decode();
        bus.decoded_rs_address = 4'd14;
        cyc(CORE_REQUEST);
        check("r14_readonly", 32'(bus.rs), 32'h04);

        // Flags and branch evaluation
        bus.decoded_nzp_write_enable = 1'b1; bus.alu_out = 8'b0000_0010;
        cyc(CORE_UPDATE);
        clear_decode();
        check("nzp_zero", 32'(bus.nzp), 32'h2);
        bus.decoded_nzp = 3'b011;
        cyc(CORE_EXECUTE);
        check("branch_taken_011", 32'(bus.branch_taken), 32'h1);
        bus.decoded_nzp = 3'b101;
        cyc(CORE_EXECUTE);
        check("branch_not_taken_101", 32'(bus.branch_taken), 32'h0);

        // Enable gating: nothing moves while enable is low
        bus.enable = 1'b0;
        bus.decoded_rs_address = 4'd1; bus.decoded_rt_address = 4'd1;
        cyc(CORE_REQUEST);
        bus.decoded_reg_write_enable = 1'b1; bus.decoded_nzp_write_enable = 1'b1;
        bus.decoded_rd_address = 4'd1; bus.alu_out = 8'h11;
        cyc(CORE_UPDATE);
        check("gated_rs", 32'(bus.rs), 32'h04);
        check("gated_rt", 32'(bus.rt), 32'h02);
        check("gated_nzp", 32'(bus.nzp), 32'h2);
        bus.enable = 1'b1;
        cyc(CORE_UPDATE);
        clear_decode();
        cyc(CORE_REQUEST);
        check("enabled_r1", 32'(bus.rs), 32'h11);
        check("enabled_nzp", 32'(bus.nzp), 32'h1);

        // Combined register + flag write, and reserved mux writes nothing
        bus.decoded_reg_write_enable = 1'b1; bus.decoded_nzp_write_enable = 1'b1;
        bus.decoded_rd_address = 4'd6; bus.decoded_reg_input_mux = REG_SRC_LSU;
        bus.lsu_out = 8'h9C; bus.alu_out = 8'h04;
        cyc(CORE_UPDATE);
        bus.decoded_nzp_write_enable = 1'b0;
        bus.decoded_rd_address = 4'd7; bus.decoded_reg_input_mux = 2'b11;
        cyc(CORE_UPDATE);
        clear_decode();
        bus.decoded_rs_address = 4'd6; bus.decoded_rt_address = 4'd7;
        cyc(CORE_REQUEST);
        check("combined_r6", 32'(bus.rs), 32'h9C);
        check("combined_nzp", 32'(bus.nzp), 32'h4);
        check("mux11_no_write", 32'(bus.rt), 32'h0);

        // Non-one-hot flags stored as-is, upper ALU bits ignored
        bus.decoded_nzp_write_enable = 1'b1; bus.alu_out = 8'hFF;
        cyc(CORE_UPDATE);
        clear_decode();
        check("nzp_all_set", 32'(bus.nzp), 32'h7);

        // Asynchronous reset mid-cycle, no clock edge needed
        #2 reset_n = 1'b0;
        #1;
        check("async_rs",  32'(bus.rs), 32'h0);
        check("async_rt",  32'(bus.rt), 32'h0);
        check("async_nzp", 32'(bus.nzp), 32'h0);
        check("async_bt",  32'(bus.branch_taken), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(CORE_REQUEST);
        check("r6_cleared", 32'(bus.rs), 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.enable                   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bus.block_id = 8'($urandom);
            bus.decoded_rd_address       = 4'($urandom);
            bus.decoded_rs_address       = 4'($urandom);
            bus.decoded_rt_address       = 4'($urandom);
            bus.decoded_reg_write_enable = 1'($urandom);
            bus.decoded_reg_input_mux    = 2'($urandom);
            bus.decoded_immediate        = 8'($urandom);
            bus.decoded_nzp_write_enable = 1'($urandom);
            bus.decoded_nzp              = 3'($urandom);
            bus.alu_out                  = 8'($urandom);
            bus.lsu_out                  = 8'($urandom);
            cyc(core_state_t'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
